// File: rtl/ex_alu_mc_pkg.sv
// rtl/ex_alu_mc_pkg.sv - op encodings, defaults and divider FSM states for ex_alu_mc
package ex_alu_mc_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int ADDRW_DEF = 5;

    typedef enum logic [3:0] {
        ALU_NOP_OP  = 4'd0,
        ALU_OR_OP   = 4'd1,
        ALU_AND_OP  = 4'd2,
        ALU_XOR_OP  = 4'd3,
        ALU_NOR_OP  = 4'd4,
        ALU_SLL_OP  = 4'd5,
        ALU_SRL_OP  = 4'd6,
        ALU_SRA_OP  = 4'd7,
        ALU_ADD_OP  = 4'd8,
        ALU_SUB_OP  = 4'd9,
        ALU_SLT_OP  = 4'd10,
        ALU_SLTU_OP = 4'd11,
        ALU_DIV_OP  = 4'd12,
        ALU_DIVU_OP = 4'd13,
        ALU_REM_OP  = 4'd14,
        ALU_REMU_OP = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    // All four divide ops share the top two opcode bits.
    function automatic logic is_div_op(input logic [3:0] op);
        return op[3:2] == 2'b11;
    endfunction

endpackage

// File: rtl/ex_alu_mc_div_iter.sv
// rtl/ex_alu_mc_div_iter.sv - iterative unsigned restoring divider, one quotient bit per cycle
module ex_div_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            abort,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] quot,
    output logic [XLEN-1:0] rem
);
    localparam int CW = $clog2(XLEN);

    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] quot_r;
    logic [XLEN-1:0] rem_r;
    logic [XLEN-1:0] div_r;
    logic            busy_r;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;

    always_comb begin
        shifted = {rem_r, quot_r[XLEN-1]};
        diff    = shifted - {1'b0, div_r};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            quot_r <= '0;
            rem_r  <= '0;
            div_r  <= '0;
            busy_r <= 1'b0;
        end else if (abort) begin
            cnt    <= '0;
            busy_r <= 1'b0;
        end else if (start) begin
            cnt    <= '0;
            quot_r <= a;
            rem_r  <= '0;
            div_r  <= b;
            busy_r <= 1'b1;
        end else if (busy_r) begin
            // Borrow out of the trial subtraction means restore the partial remainder.
            if (diff[XLEN]) begin
                rem_r  <= shifted[XLEN-1:0];
                quot_r <= {quot_r[XLEN-2:0], 1'b0};
            end else begin
                rem_r  <= diff[XLEN-1:0];
                quot_r <= {quot_r[XLEN-2:0], 1'b1};
            end
            cnt <= cnt + CW'(1);
            if (cnt == CW'(XLEN-1)) begin
                busy_r <= 1'b0;
            end
        end
    end

    assign busy = busy_r;
    assign done = busy_r && (cnt == CW'(XLEN-1));
    assign quot = quot_r;
    assign rem  = rem_r;

endmodule

// File: rtl/ex_alu_mc.sv
// rtl/ex_alu_mc.sv - execute stage: registered single-cycle ALU plus multi-cycle divider
module ex_alu_mc
    import ex_alu_mc_pkg::*;
#(
    parameter int  XLEN  = XLEN_DEF,
    parameter int  ADDRW = ADDRW_DEF,
    localparam int SHW   = $clog2(XLEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [3:0]       aluop_i,
    input  logic [XLEN-1:0]  src1_i,
    input  logic [XLEN-1:0]  src2_i,
    input  logic [ADDRW-1:0] waddr_i,
    input  logic             we_i,
    output logic             out_valid_o,
    output logic [XLEN-1:0]  res_o,
    output logic [ADDRW-1:0] waddr_o,
    output logic             we_o,
    output logic             stall_req_o
);
    div_state_e       state, state_next;
    logic [XLEN-1:0]  alu_res;
    logic [SHW-1:0]   shamt;
    logic             accept, div_acc, src2_zero, signed_op, a_neg, b_neg;
    logic [XLEN-1:0]  abs_a, abs_b;
    logic             div_start, div_busy, div_done;
    logic [XLEN-1:0]  div_quot, div_rem, div_final;

    logic             op_rem, q_neg, r_neg, divz;
    logic [XLEN-1:0]  src1_hold;
    logic [ADDRW-1:0] waddr_hold;
    logic             we_hold;

    assign in_ready_o  = (state == ST_IDLE);
    assign stall_req_o = ~in_ready_o;
    assign accept      = in_valid_i && in_ready_o && !flush_i;
    assign div_acc     = accept && is_div_op(aluop_i);
    assign src2_zero   = (src2_i == '0);
    assign div_start   = div_acc && !src2_zero;
    assign shamt       = src2_i[SHW-1:0];

    always_comb begin
        alu_res = '0;
        case (aluop_i)
            ALU_OR_OP:   alu_res = src1_i | src2_i;
            ALU_AND_OP:  alu_res = src1_i & src2_i;
            ALU_XOR_OP:  alu_res = src1_i ^ src2_i;
            ALU_NOR_OP:  alu_res = ~(src1_i | src2_i);
            ALU_SLL_OP:  alu_res = src1_i << shamt;
            ALU_SRL_OP:  alu_res = src1_i >> shamt;
            ALU_SRA_OP:  alu_res = $signed(src1_i) >>> shamt;
            ALU_ADD_OP:  alu_res = src1_i + src2_i;
            ALU_SUB_OP:  alu_res = src1_i - src2_i;
            ALU_SLT_OP:  alu_res = {{(XLEN-1){1'b0}}, $signed(src1_i) < $signed(src2_i)};
            ALU_SLTU_OP: alu_res = {{(XLEN-1){1'b0}}, src1_i < src2_i};
            default:     alu_res = '0;
        endcase
    end

    // Signed divides run on magnitudes; MIN's magnitude is still exact as unsigned.
    always_comb begin
        signed_op = (aluop_i == ALU_DIV_OP) || (aluop_i == ALU_REM_OP);
        a_neg     = signed_op && src1_i[XLEN-1];
        b_neg     = signed_op && src2_i[XLEN-1];
        abs_a     = a_neg ? (~src1_i + XLEN'(1)) : src1_i;
        abs_b     = b_neg ? (~src2_i + XLEN'(1)) : src2_i;
    end

    ex_div_iter #(.XLEN(XLEN)) u_div (
        .clk   (clk),
        .rst   (rst),
        .abort (flush_i),
        .start (div_start),
        .a     (abs_a),
        .b     (abs_b),
        .busy  (div_busy),
        .done  (div_done),
        .quot  (div_quot),
        .rem   (div_rem)
    );

    always_comb begin
        if (divz) begin
            div_final = op_rem ? src1_hold : '1;
        end else if (op_rem) begin
            div_final = r_neg ? (~div_rem + XLEN'(1)) : div_rem;
        end else begin
            div_final = q_neg ? (~div_quot + XLEN'(1)) : div_quot;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (div_acc) begin
                    state_next = src2_zero ? ST_DONE : ST_DIV;
                end
            end
            ST_DIV: begin
                if (div_done || !div_busy) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        if (flush_i) begin
            state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_o <= 1'b0;
            res_o       <= '0;
            waddr_o     <= '0;
            we_o        <= 1'b0;
            op_rem      <= 1'b0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            divz        <= 1'b0;
            src1_hold   <= '0;
            waddr_hold  <= '0;
            we_hold     <= 1'b0;
        end else if (flush_i) begin
            out_valid_o <= 1'b0;
            we_o        <= 1'b0;
        end else begin
            out_valid_o <= 1'b0;
            we_o        <= 1'b0;
            if (accept && !is_div_op(aluop_i)) begin
                out_valid_o <= 1'b1;
                res_o       <= alu_res;
                waddr_o     <= waddr_i;
                we_o        <= we_i;
            end
            if (div_acc) begin
                op_rem     <= aluop_i[1];
                q_neg      <= a_neg ^ b_neg;
                r_neg      <= a_neg;
                divz       <= src2_zero;
                src1_hold  <= src1_i;
                waddr_hold <= waddr_i;
                we_hold    <= we_i;
            end
            if (state == ST_DONE) begin
                out_valid_o <= 1'b1;
                res_o       <= div_final;
                waddr_o     <= waddr_hold;
                we_o        <= we_hold;
            end
        end
    end

endmodule
